// File: rtl/switch_debounce8.sv
// -----------------------------------------------------------------------------
// switch_debounce8
//
// Conditions the eight raw board switches before they reach the 8-to-3
// priority encoder. Each bit passes through a two-flop synchroniser and an
// independent debounce counter. Any settled change is then published as a
// latched event over a valid/ready handshake.
//
// Ports
//   clk          core clock, all flops on the rising edge
//   rst_n        asynchronous, active-low reset
//   sw_raw[7:0]  raw asynchronous switch inputs
//   sw_stable    debounced, registered switch vector (feeds the encoder)
//   evt_valid    a change event is pending
//   evt_ready    consumer accepts the pending event this cycle
//   evt_data     sw_stable value captured at the most recent change
//   evt_overrun  sticky: a pending event was overwritten before acceptance
//
// Handshake: a transfer happens on any rising edge where evt_valid=1 and
// evt_ready=1. evt_data is held while evt_valid=1 unless a newer change
// arrives, and the newest change always wins. If that newer change lands
// while the old event is unaccepted, evt_overrun is set. If it lands on the
// same edge as an accept, the old event is consumed and the new one loaded,
// so evt_valid stays 1 with no overrun. evt_ready while evt_valid=0 is ignored.
// -----------------------------------------------------------------------------
module switch_debounce8 #(
  parameter int  DEBOUNCE_CYCLES = 16,
  localparam int CNT_W           = $clog2(DEBOUNCE_CYCLES)
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] sw_raw,
  output logic [7:0] sw_stable,
  output logic       evt_valid,
  input  logic       evt_ready,
  output logic [7:0] evt_data,
  output logic       evt_overrun
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [7:0]       sync1;
  logic [7:0]       sync2;
  logic [CNT_W-1:0] cnt      [8];
  logic [CNT_W-1:0] cnt_nxt  [8];
  logic [7:0]       stable_nxt;
  logic             update;
  logic             valid_nxt;
  logic [7:0]       data_nxt;
  logic             overrun_nxt;

  // Two-flop synchroniser; only sync2 is used downstream.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= 8'h00;
      sync2 <= 8'h00;
    end else begin
      sync1 <= sw_raw;
      sync2 <= sync1;
    end
  end

  // Per-bit debounce: the counter only advances while sync2 disagrees with
  // the stable value. Any return to agreement clears it, so the stable bit
  // flips only after DEBOUNCE_CYCLES consecutive disagreeing edges.
  always_comb begin
    stable_nxt = sw_stable;
    for (int i = 0; i < 8; i++) begin
      cnt_nxt[i] = '0;
      if (sync2[i] != sw_stable[i]) begin
        if (cnt[i] == CNT_LAST) begin
          stable_nxt[i] = sync2[i];
        end else begin
          cnt_nxt[i] = cnt[i] + CNT_W'(1);
        end
      end
    end
  end

  assign update = |(stable_nxt ^ sw_stable);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sw_stable <= 8'h00;
      for (int i = 0; i < 8; i++) begin
        cnt[i] <= '0;
      end
    end else begin
      sw_stable <= stable_nxt;
      for (int i = 0; i < 8; i++) begin
        cnt[i] <= cnt_nxt[i];
      end
    end
  end

  // Event slot. evt_valid is the whole state of this small machine and is
  // already visible on the port. An update always loads the slot. Without an
  // update, an accepted event empties it.
  always_comb begin
    valid_nxt   = evt_valid;
    data_nxt    = evt_data;
    overrun_nxt = evt_overrun;
    if (update) begin
      valid_nxt = 1'b1;
      data_nxt  = stable_nxt;
      if (evt_valid && !evt_ready) begin
        overrun_nxt = 1'b1;
      end
    end else if (evt_valid && evt_ready) begin
      valid_nxt = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      evt_valid   <= 1'b0;
      evt_data    <= 8'h00;
      evt_overrun <= 1'b0;
    end else begin
      evt_valid   <= valid_nxt;
      evt_data    <= data_nxt;
      evt_overrun <= overrun_nxt;
    end
  end

endmodule

// File: tb/tb_switch_debounce8.sv
// -----------------------------------------------------------------------------
// tb_switch_debounce8
//
// Drives switch_debounce8 (DEBOUNCE_CYCLES=4) through directed scenarios
// followed by random switch activity, random consumer readiness and occasional
// resets. The reference model keeps a history of the raw vector seen at each
// edge. Because of the two synchroniser stages, the value debounced at edge t
// is the raw value from edge t-2. A stable bit flips at edge t when the last
// D such values all differ from it. Outputs are compared on every falling edge.
// -----------------------------------------------------------------------------
module tb_switch_debounce8;

  localparam int D = 4;

  // ---------------- clock / reset ----------------
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] sw_raw = 8'h00;
  logic       evt_ready = 1'b0;
  logic [7:0] sw_stable;
  logic       evt_valid;
  logic [7:0] evt_data;
  logic       evt_overrun;

  always #5 clk = ~clk;

  switch_debounce8 #(.DEBOUNCE_CYCLES(D)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .sw_raw      (sw_raw),
    .sw_stable   (sw_stable),
    .evt_valid   (evt_valid),
    .evt_ready   (evt_ready),
    .evt_data    (evt_data),
    .evt_overrun (evt_overrun)
  );

  // ---------------- reference model ----------------
  logic [7:0] hist [D+1];   // hist[0] = raw at the previous edge, hist[1] = two edges back, ...
  logic [7:0] m_stable;
  logic       m_valid;
  logic [7:0] m_data;
  logic       m_overrun;

  int vectors = 0;
  int miscompares = 0;

  task automatic model_reset();
    for (int k = 0; k <= D; k++) hist[k] = 8'h00;
    m_stable  = 8'h00;
    m_valid   = 1'b0;
    m_data    = 8'h00;
    m_overrun = 1'b0;
  endtask

  // Called once per rising edge with the inputs present at that edge.
  task automatic model_step();
    logic [7:0] nxt;
    bit         all_diff;
    if (!rst_n) begin
      model_reset();
      return;
    end
    nxt = m_stable;
    for (int i = 0; i < 8; i++) begin
      all_diff = 1'b1;
      for (int k = 1; k <= D; k++) begin
        if (hist[k][i] == m_stable[i]) all_diff = 1'b0;
      end
      if (all_diff) nxt[i] = ~m_stable[i];
    end
    if (nxt != m_stable) begin
      if (m_valid && !evt_ready) m_overrun = 1'b1;
      m_valid = 1'b1;
      m_data  = nxt;
    end else if (m_valid && evt_ready) begin
      m_valid = 1'b0;
    end
    m_stable = nxt;
    for (int k = D; k > 0; k--) hist[k] = hist[k-1];
    hist[0] = sw_raw;
  endtask

  // ---------------- scoreboard ----------------
  task automatic check(input string nm, input logic [7:0] act, input logic [7:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s t=%0t actual=%h expected=%h", nm, $time, act, exp);
    end
  endtask

  task automatic compare();
    check("sw_stable",   sw_stable,            m_stable);
    check("evt_valid",   {7'b0, evt_valid},    {7'b0, m_valid});
    check("evt_data",    evt_data,             m_data);
    check("evt_overrun", {7'b0, evt_overrun},  {7'b0, m_overrun});
  endtask

  // Downstream 8-to-3 priority encoder, highest set bit wins.
  function automatic logic [7:0] prio(input logic [7:0] x);
    prio = 8'h00;
    for (int i = 0; i < 8; i++) if (x[i]) prio = 8'(i);
  endfunction

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    compare();
  endtask

  task automatic do_reset(input logic [7:0] raw);
    rst_n     = 1'b0;
    sw_raw    = raw;
    evt_ready = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    model_reset();
    @(negedge clk);

    // Reset with all switches high, then release: flip at edge 6.
    do_reset(8'hFF);
    check("rst_stable", sw_stable, 8'h00);
    check("rst_valid",  {7'b0, evt_valid}, 8'h00);
    repeat (5) tick();
    check("rel_e5_stable", sw_stable, 8'h00);
    tick();
    check("rel_e6_stable", sw_stable, 8'hFF);
    check("rel_e6_valid",  {7'b0, evt_valid}, 8'h01);
    check("rel_e6_data",   evt_data, 8'hFF);
    evt_ready = 1'b1;
    tick();

    // Clean step on bit 7, consumer always ready.
    do_reset(8'h00);
    evt_ready = 1'b1;
    sw_raw    = 8'h80;
    repeat (6) tick();
    check("step_stable", sw_stable, 8'h80);
    check("step_valid",  {7'b0, evt_valid}, 8'h01);
    check("step_enc_y",  prio(sw_stable), 8'h07);
    tick();
    check("step_valid_drop", {7'b0, evt_valid}, 8'h00);

    // Bounce on bit 3 every 2 cycles for 20 cycles, then settle high.
    for (int k = 0; k < 5; k++) begin
      sw_raw[3] = 1'b1; tick(); tick();
      sw_raw[3] = 1'b0; tick(); tick();
    end
    check("bounce_held", sw_stable, 8'h80);
    sw_raw[3] = 1'b1;
    repeat (5) tick();
    check("bounce_e5", sw_stable, 8'h80);
    tick();
    check("bounce_e6", sw_stable, 8'h88);
    check("bounce_evt", {7'b0, evt_valid}, 8'h01);
    tick();
    check("bounce_once", {7'b0, evt_valid}, 8'h00);

    // Two bits rising together give a single event.
    do_reset(8'h00);
    sw_raw = 8'h21;
    repeat (6) tick();
    check("multi_data",  evt_data, 8'h21);
    check("multi_valid", {7'b0, evt_valid}, 8'h01);
    evt_ready = 1'b1;
    tick();
    check("multi_once", {7'b0, evt_valid}, 8'h00);

    // Overrun: second change while first is still pending.
    do_reset(8'h00);
    sw_raw = 8'h02;
    repeat (8) tick();
    sw_raw = 8'h06;
    repeat (8) tick();
    check("ovr_data",    evt_data, 8'h06);
    check("ovr_valid",   {7'b0, evt_valid}, 8'h01);
    check("ovr_flag",    {7'b0, evt_overrun}, 8'h01);
    evt_ready = 1'b1;
    tick();
    evt_ready = 1'b0;
    check("ovr_accept",  {7'b0, evt_valid}, 8'h00);
    check("ovr_sticky",  {7'b0, evt_overrun}, 8'h01);

    // Accept and reload on the same edge.
    do_reset(8'h00);
    sw_raw = 8'h01;
    repeat (8) tick();
    sw_raw = 8'h03;
    repeat (5) tick();
    evt_ready = 1'b1;
    tick();
    check("reload_valid",   {7'b0, evt_valid}, 8'h01);
    check("reload_data",    evt_data, 8'h03);
    check("reload_overrun", {7'b0, evt_overrun}, 8'h00);

    // Random activity against the model.
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 9) == 0) sw_raw[$urandom_range(0, 7)] ^= 1'b1;
      if ($urandom_range(0, 60) == 0) sw_raw = 8'($urandom);
      evt_ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 400) == 0) rst_n = 1'b0;
      else rst_n = 1'b1;
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/switch_debounce8.md
# switch_debounce8

Input conditioning stage that sits directly upstream of the 8-to-3 priority encoder and its seven-segment decoder. It synchronises the eight raw board switches into the core clock domain and debounces each bit independently. It drives the encoder's 8-bit input with a glitch-free vector. It also emits a latched change event with a valid/ready handshake, so a consumer (LED/status logic, testbench monitor) sees every settled switch change exactly once.

## Interface
- DEBOUNCE_CYCLES, 16, consecutive cycles a synchronised bit must disagree with its stable value before the stable value flips; legal range 2..65535
- CNT_W, $clog2(DEBOUNCE_CYCLES), per-bit counter width (derived, not overridden)

- clk  in  1  core clock; all flops on rising edge
- rst_n  in  1  asynchronous, active-low reset
- sw_raw  in  8  raw asynchronous switch inputs
- sw_stable  out  8  debounced switch vector; feeds encoder input x
- evt_valid  out  1  change event pending
- evt_ready  in  1  consumer accepts event this cycle
- evt_data  out  8  sw_stable value captured at the most recent change
- evt_overrun  out  1  sticky; an unaccepted event was overwritten

## Operation
- Per bit i: two-flop synchroniser sync1[i] -> sync2[i]. Debounce uses sync2 only.
- Per bit i: counter cnt[i] (CNT_W bits). Rules at each edge:
  - sync2[i] == sw_stable[i]: cnt[i] <= 0.
  - sync2[i] != sw_stable[i] and cnt[i] == DEBOUNCE_CYCLES-1: sw_stable[i] <= sync2[i], cnt[i] <= 0.
  - sync2[i] != sw_stable[i] otherwise: cnt[i] <= cnt[i]+1.
  - Any bounce back to agreement clears the counter; there is no partial credit.
- Bits are fully independent. Several bits may flip on the same edge.
- Event logic, evaluated on the edge where one or more sw_stable bits flip ("update"):
  - evt_data <= next value of sw_stable (all 8 bits, post-update); evt_valid <= 1.
  - Update while evt_valid=1 and evt_ready=0: evt_data overwritten (latest wins), evt_overrun <= 1.
  - Update while evt_valid=1 and evt_ready=1: accept and reload in the same edge; evt_valid stays 1; no overrun.
  - No update, evt_valid=1, evt_ready=1: evt_valid <= 0.
  - evt_ready while evt_valid=0: ignored.
- evt_overrun clears only on reset.
- evt_data is held stable while evt_valid=1 and no update occurs.

## Timing
- Reset (rst_n=0, asynchronous assert; release is synchronous to clk by the system): sync1, sync2, cnt, sw_stable = 0; evt_valid = 0; evt_data = 8'h00; evt_overrun = 0.
- Reset mid-debounce discards all progress. After release, any switch held high re-debounces from 0 and produces a fresh event.
- Latency: sw_raw bit changes before edge 1 and stays put. sync2 reflects it after edge 2. sw_stable flips at edge DEBOUNCE_CYCLES+2. evt_valid rises on that same edge.
- A glitch on sync2 lasting fewer than DEBOUNCE_CYCLES cycles never reaches sw_stable.
- sw_stable is registered and may go straight into the combinational encoder.
- Handshake: a transfer occurs on an edge where evt_valid=1 and evt_ready=1. Throughput is at most one event per cycle.

## Test plan
- Reset: hold rst_n=0 with sw_raw=8'hFF -> all outputs 0. Release with DEBOUNCE_CYCLES=4 -> sw_stable=8'hFF and evt_valid=1 at edge 6 after release, evt_data=8'hFF.
- Clean step: sw_raw 8'h00->8'h80 before edge 1, evt_ready=1 -> sw_stable=8'h80 at edge 6. evt_valid high exactly one cycle. Encoder downstream then shows y=7.
- Bounce rejection: bit 3 toggles every 2 cycles for 20 cycles, then settles at 1 -> sw_stable[3] stays 0 during toggling. It flips to 1 exactly 6 edges after the final sw_raw transition. Exactly one event.
- Multi-bit same edge: bits 0 and 5 rise together -> single event with evt_data=8'h21.
- Overrun: evt_ready=0; bit 1 rises then, after settling, bit 2 rises -> evt_data=8'h06, evt_valid=1, evt_overrun=1. Asserting evt_ready for one cycle -> evt_valid=0, evt_overrun remains 1.
- Accept + reload: an update lands on the same edge as evt_valid=1 and evt_ready=1 -> evt_valid stays 1, evt_data takes the new value, evt_overrun stays 0.
